// File: rtl/pwf_pkg.sv
// Shared definitions for the pulse-width filter scan controller.
//   - default parameter values for the channel count, counter width and threshold
//   - pwf_evt_t: one queued edge event (channel number and edge direction)
//   - ev_state_t: states of the event delivery FSM
package pwf_pkg;

    localparam int PWF_N_CH_DEF  = 8;
    localparam int PWF_CNT_W_DEF = 4;
    localparam int PWF_THR_DEF   = 12;

    // The channel field is wide enough for the largest supported channel count (16).
    localparam int PWF_CH_W = 4;

    typedef struct packed {
        logic [PWF_CH_W-1:0] ch;
        logic                rise;
    } pwf_evt_t;

    typedef enum logic {
        EV_IDLE,
        EV_HOLD
    } ev_state_t;

endpackage

// File: rtl/pwf_rr_arb.sv
// Combinational round-robin arbiter.
// Picks the first set request bit at or after ptr, wrapping at N_CH.
//   req       : request vector, one bit per channel
//   ptr       : channel index to start searching from
//   grant     : one-hot grant (all zero when there is no request)
//   grant_idx : binary index of the granted channel
//   any_req   : at least one request bit is set
module pwf_rr_arb #(
    parameter int N_CH  = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    // The search runs from the farthest offset down to offset 0, so the last hit
    // written is the one closest to ptr. That avoids needing a loop break.
    always_comb begin
        int ch;
        ch        = 0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int off = N_CH - 1; off >= 0; off--) begin
            ch = int'(ptr) + off;
            if (ch >= N_CH) begin
                ch = ch - N_CH;
            end
            if (req[ch]) begin
                grant     = '0;
                grant[ch] = 1'b1;
                grant_idx = IDX_W'(ch);
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwf_scan_ctrl.sv
// Multi-channel pulse-width filter controller.
// A single counter/compare datapath visits one channel per enabled cycle in
// round-robin order. A channel's filtered level rises after thr+1 consecutive
// high visits. It drops on the first low visit. Every level change is queued
// as a pending event for that channel. Pending events are delivered one at a
// time through a valid/ready port, and a round-robin arbiter chooses which
// pending channel goes next.
//   clk11m    : system clock
//   rst_n     : asynchronous active-low reset
//   en        : scan enable (0 freezes the scan pointer, counters and levels)
//   thr       : qualify threshold, sampled at each visit
//   g         : raw asynchronous inputs
//   i         : filtered levels
//   scan_wrap : one-cycle pulse after the visit to the last channel
//   evt_*     : event port (valid/ready), evt_rise = 1 for a rising edge
//   evt_ovf   : sticky flag, set when a still-pending event is overwritten
//   ovf_clr   : clears evt_ovf
module pwf_scan_ctrl
    import pwf_pkg::*;
#(
    parameter int N_CH  = PWF_N_CH_DEF,
    parameter int CNT_W = PWF_CNT_W_DEF
) (
    input  logic                    clk11m,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [CNT_W-1:0]        thr,
    input  logic [N_CH-1:0]         g,
    output logic [N_CH-1:0]         i,
    output logic                    scan_wrap,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_rise,
    input  logic                    evt_ready,
    output logic                    evt_ovf,
    input  logic                    ovf_clr
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    logic [N_CH-1:0]  g_meta_q, gs_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [N_CH-1:0]  i_q;
    logic             scan_wrap_q;
    logic [N_CH-1:0]  pend_q, pend_d, type_q, type_d;
    ev_state_t        state_q, state_d;
    pwf_evt_t         evt_q, evt_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;

    // Shared visit datapath for the channel at idx_q.
    logic [CNT_W-1:0] cur_cnt, cnt_nxt;
    logic             cur_gs, cur_i, i_nxt, post, post_rise, post_vld;

    logic [N_CH-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_req, take;
    logic             ch_hi_unused;

    assign cur_cnt = cnt_q[idx_q];
    assign cur_gs  = gs_q[idx_q];
    assign cur_i   = i_q[idx_q];
    assign idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        cnt_nxt   = cur_cnt;
        i_nxt     = cur_i;
        post      = 1'b0;
        post_rise = 1'b0;
        if (!cur_gs) begin
            cnt_nxt = '0;
            if (cur_i) begin
                i_nxt = 1'b0;
                post  = 1'b1;
            end
        end else if (!cur_i) begin
            if (cur_cnt >= thr) begin
                i_nxt     = 1'b1;
                post      = 1'b1;
                post_rise = 1'b1;
            end else if (cur_cnt != '1) begin
                cnt_nxt = cur_cnt + 1'b1;
            end
        end
    end

    assign post_vld = en && post;

    pwf_rr_arb #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (pend_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_d     = state_q;
        evt_d       = evt_q;
        evt_valid_d = evt_valid_q;
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        type_d      = type_q;
        ovf_d       = ovf_q;
        take        = 1'b0;
        case (state_q)
            EV_IDLE: begin
                if (any_req) begin
                    take        = 1'b1;
                    evt_d.ch    = PWF_CH_W'(grant_idx);
                    evt_d.rise  = type_q[grant_idx];
                    evt_valid_d = 1'b1;
                    pend_d      = pend_q & ~grant;
                    ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d     = EV_HOLD;
                end
            end
            EV_HOLD: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = EV_IDLE;
                end
            end
            default: state_d = EV_IDLE;
        endcase
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // A post that lands on the channel being granted this cycle is not an
        // overflow. The grant carries the old edge, and the new edge stays pending.
        // The post is applied after the clear, so a simultaneous overflow wins.
        if (post_vld) begin
            if (pend_q[idx_q] && !(take && grant_idx == idx_q)) begin
                ovf_d = 1'b1;
            end
            pend_d[idx_q] = 1'b1;
            type_d[idx_q] = post_rise;
        end
    end

    always_ff @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            g_meta_q    <= '0;
            gs_q        <= '0;
            idx_q       <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
            end
            i_q         <= '0;
            scan_wrap_q <= 1'b0;
            pend_q      <= '0;
            type_q      <= '0;
            state_q     <= EV_IDLE;
            evt_q       <= '0;
            evt_valid_q <= 1'b0;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            g_meta_q    <= g;
            gs_q        <= g_meta_q;
            scan_wrap_q <= en && (idx_q == LAST_IDX);
            if (en) begin
                idx_q        <= idx_d;
                cnt_q[idx_q] <= cnt_nxt;
                i_q[idx_q]   <= i_nxt;
            end
            pend_q      <= pend_d;
            type_q      <= type_d;
            state_q     <= state_d;
            evt_q       <= evt_d;
            evt_valid_q <= evt_valid_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    // The stored channel field may be wider than this instance needs.
    assign ch_hi_unused = ^evt_q.ch;

    assign i         = i_q;
    assign scan_wrap = scan_wrap_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_q.ch[IDX_W-1:0];
    assign evt_rise  = evt_q.rise;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_pwf_scan_ctrl.sv
module tb_pwf_scan_ctrl;

    logic       clk11m = 1'b0;
    logic       rst_n, en, evt_ready, ovf_clr;
    logic [3:0] thr;
    logic [7:0] g;
    logic [7:0] i;
    logic       scan_wrap, evt_valid, evt_rise, evt_ovf;
    logic [2:0] evt_ch;

    int total = 0;
    int bad   = 0;

    always #45 clk11m = ~clk11m;

    pwf_scan_ctrl #(.N_CH(8), .CNT_W(4)) dut (
        .clk11m    (clk11m),
        .rst_n     (rst_n),
        .en        (en),
        .thr       (thr),
        .g         (g),
        .i         (i),
        .scan_wrap (scan_wrap),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; thr = 4'd12; g = 8'h00; evt_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(negedge clk11m);
        rst_n = 1'b1;
    endtask

    // Bounded wait. It returns on the negedge where scan_wrap is high, which is the idx0 cycle.
    task automatic wait_wrap(input string tag);
        int n;
        n = 0;
        @(negedge clk11m);
        while (scan_wrap !== 1'b1 && n < 20) begin
            @(negedge clk11m);
            n++;
        end
        total++;
        if (scan_wrap !== 1'b1) begin
            bad++;
            $display("FAIL %s_wrap_wait got=%b want=1", tag, scan_wrap);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; thr = 4'd0; g = 8'h00; evt_ready = 1'b1; ovf_clr = 1'b0;
        @(negedge clk11m);
        total++;
        if ({i, evt_valid, evt_ovf, scan_wrap, evt_ch, evt_rise} !== 15'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {i, evt_valid, evt_ovf, scan_wrap, evt_ch, evt_rise});
        end
        rst_n = 1'b1;
        g = 8'hFF;
        repeat (13) @(negedge clk11m);
        total++;
        if (i !== 8'hFF) begin bad++; $display("FAIL reset_prefill_i got=%h want=ff", i); end
        #10 rst_n = 1'b0;
        #1;
        total++;
        if (i !== 8'h00 || evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got i=%h v=%b ovf=%b want 00/0/0", i, evt_valid, evt_ovf);
        end
        g = 8'h00; thr = 4'd12;
        repeat (2) @(negedge clk11m);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk11m);
            total++;
            if (scan_wrap !== 1'b0) begin bad++; $display("FAIL reset_idx_early cyc=%0d got=%b want=0", k, scan_wrap); end
        end
        @(negedge clk11m);
        total++;
        if (scan_wrap !== 1'b1) begin bad++; $display("FAIL reset_idx_wrap got=%b want=1", scan_wrap); end
    endtask

    task automatic test_qualify();
        do_reset();
        wait_wrap("qualify");
        g = 8'h08;
        repeat (99) @(negedge clk11m);
        total++;
        if (i !== 8'h00) begin bad++; $display("FAIL qualify_before got=%h want=00", i); end
        @(negedge clk11m);
        total++;
        if (i !== 8'h08 || evt_valid !== 1'b0) begin bad++; $display("FAIL qualify_rise got i=%h v=%b want 08/0", i, evt_valid); end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 3'd3 || evt_rise !== 1'b1) begin
            bad++;
            $display("FAIL qualify_evt got v=%b ch=%0d r=%b want 1/3/1", evt_valid, evt_ch, evt_rise);
        end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL qualify_accept got v=%b want 0", evt_valid); end
        repeat (16) @(negedge clk11m);
        total++;
        if (i !== 8'h08 || evt_valid !== 1'b0) begin bad++; $display("FAIL qualify_quiet got i=%h v=%b want 08/0", i, evt_valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        wait_wrap("glitch");
        g = 8'h20;
        repeat (40) @(negedge clk11m);
        g = 8'h00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk11m);
            total++;
            if (i !== 8'h00 || evt_valid !== 1'b0) begin
                bad++;
                $display("FAIL glitch_quiet cyc=%0d got i=%h v=%b want 00/0", k, i, evt_valid);
            end
        end
        // The counter must restart from 0, so it again takes a full 13 visits.
        g = 8'h20;
        repeat (101) @(negedge clk11m);
        total++;
        if (i !== 8'h00) begin bad++; $display("FAIL glitch_cnt_cleared got=%h want=00", i); end
        @(negedge clk11m);
        total++;
        if (i !== 8'h20) begin bad++; $display("FAIL glitch_requalify got=%h want=20", i); end
    endtask

    task automatic test_fall_arb();
        do_reset();
        thr = 4'd0;
        g = 8'h42;
        repeat (24) @(negedge clk11m);
        total++;
        if (i !== 8'h42 || evt_valid !== 1'b0) begin bad++; $display("FAIL arb_setup got i=%h v=%b want 42/0", i, evt_valid); end
        wait_wrap("arb");
        repeat (6) @(negedge clk11m);
        evt_ready = 1'b0;
        g = 8'h00;
        repeat (5) @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 3'd1 || evt_rise !== 1'b0) begin
            bad++;
            $display("FAIL arb_first got v=%b ch=%0d r=%b want 1/1/0", evt_valid, evt_ch, evt_rise);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk11m);
            total++;
            if (evt_valid !== 1'b1 || evt_ch !== 3'd1 || evt_rise !== 1'b0) begin
                bad++;
                $display("FAIL arb_hold cyc=%0d got v=%b ch=%0d r=%b want 1/1/0", k, evt_valid, evt_ch, evt_rise);
            end
        end
        evt_ready = 1'b1;
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL arb_idle_gap got v=%b want 0", evt_valid); end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 3'd6 || evt_rise !== 1'b0) begin
            bad++;
            $display("FAIL arb_second got v=%b ch=%0d r=%b want 1/6/0", evt_valid, evt_ch, evt_rise);
        end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b0 || i !== 8'h00) begin bad++; $display("FAIL arb_done got v=%b i=%h want 0/00", evt_valid, i); end
    endtask

    task automatic test_overflow();
        do_reset();
        thr = 4'd0;
        evt_ready = 1'b0;
        g = 8'h01;
        repeat (16) @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 3'd0 || evt_rise !== 1'b1) begin
            bad++;
            $display("FAIL ovf_block got v=%b ch=%0d r=%b want 1/0/1", evt_valid, evt_ch, evt_rise);
        end
        g = 8'h05;
        repeat (16) @(negedge clk11m);
        total++;
        if (i !== 8'h05 || evt_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pending got i=%h ovf=%b want 05/0", i, evt_ovf); end
        g = 8'h01;
        repeat (16) @(negedge clk11m);
        total++;
        if (i !== 8'h01 || evt_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got i=%h ovf=%b want 01/1", i, evt_ovf); end
        evt_ready = 1'b1;
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_gap got v=%b want 0", evt_valid); end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b1 || evt_ch !== 3'd2 || evt_rise !== 1'b0) begin
            bad++;
            $display("FAIL ovf_evt got v=%b ch=%0d r=%b want 1/2/0", evt_valid, evt_ch, evt_rise);
        end
        @(negedge clk11m);
        total++;
        if (evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got v=%b ovf=%b want 0/1", evt_valid, evt_ovf); end
        ovf_clr = 1'b1;
        @(negedge clk11m);
        ovf_clr = 1'b0;
        total++;
        if (evt_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want 0", evt_ovf); end
    endtask

    task automatic test_freeze();
        do_reset();
        wait_wrap("freeze");
        g = 8'h01;
        repeat (27) @(negedge clk11m);
        en = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk11m);
            total++;
            if (scan_wrap !== 1'b0 || i !== 8'h00) begin
                bad++;
                $display("FAIL freeze_hold cyc=%0d got sw=%b i=%h want 0/00", k, scan_wrap, i);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk11m);
            total++;
            if (scan_wrap !== 1'b0) begin bad++; $display("FAIL freeze_idx_early cyc=%0d got=%b want 0", k, scan_wrap); end
        end
        @(negedge clk11m);
        total++;
        if (scan_wrap !== 1'b1) begin bad++; $display("FAIL freeze_idx_wrap got=%b want 1", scan_wrap); end
        // Three visits were counted before the freeze, so ten more are needed.
        repeat (72) @(negedge clk11m);
        total++;
        if (i !== 8'h00) begin bad++; $display("FAIL freeze_cnt_before got=%h want=00", i); end
        @(negedge clk11m);
        total++;
        if (i !== 8'h01) begin bad++; $display("FAIL freeze_cnt_rise got=%h want=01", i); end
    endtask

    task automatic test_thr_zero();
        do_reset();
        thr = 4'd0;
        wait_wrap("thr0");
        g = 8'h01;
        repeat (8) @(negedge clk11m);
        total++;
        if (i !== 8'h00) begin bad++; $display("FAIL thr0_before got=%h want=00", i); end
        @(negedge clk11m);
        total++;
        if (i !== 8'h01) begin bad++; $display("FAIL thr0_first_visit got=%h want=01", i); end
    endtask

    task automatic test_thr_change();
        do_reset();
        wait_wrap("thrchg");
        g = 8'h01;
        repeat (41) @(negedge clk11m);
        thr = 4'd3;
        repeat (7) @(negedge clk11m);
        total++;
        if (i !== 8'h00) begin bad++; $display("FAIL thrchg_before got=%h want=00", i); end
        @(negedge clk11m);
        total++;
        if (i !== 8'h01) begin bad++; $display("FAIL thrchg_rise got=%h want=01", i); end
    endtask

    initial begin
        test_reset();
        test_qualify();
        test_glitch();
        test_fall_arb();
        test_overflow();
        test_freeze();
        test_thr_zero();
        test_thr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwf_scan_ctrl.md
Name: pwf_scan_ctrl

Overview:
- Multi-channel pulse-width filter controller. Scans N_CH raw switch inputs round-robin through one shared counter/compare datapath on clk11m.
- Each channel is qualified high only after it stays high for a programmable number of consecutive visits. Low drops the output immediately on the next visit.
- Filtered levels go to downstream logic. Edge events are queued per channel and delivered through a round-robin-arbitrated valid/ready event port.

Parameters:
N_CH, 8, number of input channels (2..16)
CNT_W, 4, width of per-channel qualify counter and threshold

Ports:
clk11m  in  1  system clock, 11 MHz
rst_n  in  1  reset, asynchronous, active-low
en  in  1  scan enable; 0 freezes scan pointer and counters
thr  in  CNT_W  qualify threshold, read at every visit
g  in  N_CH  raw asynchronous channel inputs
i  out  N_CH  filtered channel levels
scan_wrap  out  1  one-cycle pulse when the visit to channel N_CH-1 completes
evt_valid  out  1  event available
evt_ch  out  $clog2(N_CH)  channel of presented event
evt_rise  out  1  1 = rising edge of i, 0 = falling edge
evt_ready  in  1  consumer accepts event
evt_ovf  out  1  sticky flag: an event was overwritten before delivery
ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset, asynchronous: i=0, all counters=0, pending=0, scan idx=0, scan_wrap=0, evt_valid=0, evt_ch=0, evt_rise=0, evt_ovf=0, arbiter pointer=0.
- Synchronisation: g passes through a 2-FF synchroniser (gs). Filter logic uses gs only.
- Scan:
  - When en=1, idx advances by 1 every cycle and wraps N_CH-1 -> 0. Each channel is visited once every N_CH cycles.
  - When en=0, idx, counters and i hold. The event path keeps draining.
- Visit of channel k (registered at end of the cycle idx==k with en=1):
  - gs[k]=0: cnt[k]<=0. If i[k]=1: i[k]<=0 and post a fall event.
  - gs[k]=1, i[k]=0, cnt[k]>=thr: i[k]<=1 and post a rise event. cnt holds.
  - gs[k]=1, i[k]=0, cnt[k]<thr: cnt[k]<=cnt[k]+1. The counter saturates at all-ones and never wraps.
  - gs[k]=1, i[k]=1: no change.
  - Net effect: i rises on the (thr+1)-th consecutive high visit. thr=0 means it rises on the first high visit.
- Event posting: sets pend[k] and stores type[k]. If pend[k] is already set, the type is overwritten with the new edge and evt_ovf<=1.
- Event FSM:
  - EV_IDLE: if any pend bit is set, pwf_rr_arb grants the first pending channel at or after ptr. Next cycle: evt_valid=1, evt_ch/evt_rise loaded, pend[grant] cleared, ptr<=grant+1 mod N_CH. Go to EV_HOLD.
  - EV_HOLD: evt_valid, evt_ch and evt_rise stay stable until evt_valid&&evt_ready. On accept: evt_valid<=0, go to EV_IDLE.
  - There is one idle cycle between consecutive events. Minimum latency from posting to evt_valid is 1 cycle.
- Simultaneous events:
  - Post on a channel in the same cycle it is granted: the grant takes the old type and pend stays set with the new type. This is not an overflow.
  - ovf_clr and a new overflow in the same cycle: evt_ovf ends at 1.
- scan_wrap pulses on the cycle after the visit to N_CH-1 (en=1 only).
- Changing thr mid-count takes effect at the next visit. A counter already above the new thr qualifies at that visit.

Decomposition:
- Package pwf_pkg:
  - PWF_N_CH_DEF=8, PWF_CNT_W_DEF=4, PWF_THR_DEF=12.
  - typedef pwf_evt_t {ch, rise}.
  - typedef enum ev_state_t {EV_IDLE, EV_HOLD}.
- Sub-module pwf_rr_arb: N_CH-bit request vector plus pointer in, one-hot grant, index and any_req out. Combinational; the pointer register stays in the parent.

Test Plan:
- Reset: assert rst_n=0 mid-scan with g=all-ones -> i=0, evt_valid=0, evt_ovf=0 immediately (asynchronous); after release, idx restarts at 0.
- Qualify: N_CH=8, thr=12, g[3]=1 held, evt_ready=1 -> i[3] rises at the end of the 13th visit of ch3; one event ch=3 rise=1 is accepted; no other channel changes.
- Glitch reject: thr=12, g[5]=1 for 5 visits, then 0 -> i[5] stays 0, no event, cnt[5] returns to 0.
- Fall and arbitration: i[1]=i[6]=1, drop g[1] and g[6] together, evt_ready=0 for 20 cycles -> evt_valid holds ch=1 rise=0 stable; after ready is raised, the next event is ch=6 rise=0 with exactly one idle cycle between them.
- Overflow: ch2 rises then falls while its event is still pending (evt_ready=0) -> evt_ovf=1, the delivered event is ch=2 rise=0; pulse ovf_clr -> evt_ovf=0.
- Freeze and thr=0: en=0 for 30 cycles mid-count -> cnt and idx unchanged, scan_wrap silent. Then thr=0, en=1 with g[0] high -> i[0] rises on its first visit.
